// File: rtl/md_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: MDIV-class op codes and
// the iteration state machine.
package md_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'd0,
    MD_DIVU  = 2'd1,
    MD_MTHI  = 2'd2,
    MD_MTLO  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_MUL  = 2'd1,
    MDS_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_divstep.sv
// One unsigned restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor if that does not borrow.
module md_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dividend_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  // The shifted remainder needs WIDTH+1 bits; the top bit is the borrow.
  assign w_shifted = {i_rem, i_dividend_msb};
  assign w_trial   = w_shifted - {1'b0, i_divisor};
  assign o_q_bit   = ~w_trial[WIDTH];
  assign o_rem     = o_q_bit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/md_unit.sv
// Iterative radix-2 HI/LO multiply/divide unit for the EX stage: MULTU/DIVU
// take WIDTH cycles, MTHI/MTLO write in one.
module md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import md_unit_pkg::*;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_opnd;     // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] r_shift;    // multiplier shifting right, or dividend/quotient shifting left
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_div_zero;

  logic               w_last;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic               w_q_bit;
  logic [WIDTH-1:0]   w_quo_nxt;

  assign w_last = (r_cnt == LAST_CNT);

  // Multiply step: add into the upper half with carry kept, then shift right.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_shift[0] ? {1'b0, r_opnd} : '0);
  assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};

  md_divstep #(.WIDTH(WIDTH)) u_divstep (
    .i_rem          (r_rem),
    .i_dividend_msb (r_shift[WIDTH-1]),
    .i_divisor      (r_opnd),
    .o_rem          (w_rem_nxt),
    .o_q_bit        (w_q_bit)
  );
  assign w_quo_nxt = {r_shift[WIDTH-2:0], w_q_bit};

  // NOTE: next-state is defaulted to the current state first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MDS_IDLE: begin
        if (start) begin
          if (md_op_e'(md_op) == MD_MULTU)     w_state_nxt = MDS_MUL;
          else if (md_op_e'(md_op) == MD_DIVU) w_state_nxt = MDS_DIV;
        end
      end
      MDS_MUL, MDS_DIV: if (w_last) w_state_nxt = MDS_IDLE;
      default:          w_state_nxt = MDS_IDLE;
    endcase
  end

  // NOTE: all state here is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= MDS_IDLE;
      r_cnt      <= '0;
      r_opnd     <= '0;
      r_shift    <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        MDS_IDLE: begin
          if (start) begin
            case (md_op_e'(md_op))
              MD_MTHI: r_hi <= op_a;
              MD_MTLO: r_lo <= op_a;
              MD_MULTU: begin
                r_opnd  <= op_a;
                r_shift <= op_b;
                r_acc   <= '0;
                r_cnt   <= '0;
              end
              MD_DIVU: begin
                r_opnd     <= op_b;
                r_shift    <= op_a;
                r_rem      <= '0;
                r_cnt      <= '0;
                r_div_zero <= (op_b == '0);
              end
              default: ;
            endcase
          end
        end
        MDS_MUL: begin
          r_acc   <= w_acc_nxt;
          r_shift <= r_shift >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_hi   <= w_acc_nxt[2*WIDTH-1:WIDTH];
            r_lo   <= w_acc_nxt[WIDTH-1:0];
            r_done <= 1'b1;
          end
        end
        MDS_DIV: begin
          r_rem   <= w_rem_nxt;
          r_shift <= w_quo_nxt;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_hi   <= w_rem_nxt;
            r_lo   <= w_quo_nxt;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != MDS_IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: hand-computed HI/LO results, timing, back-to-back
// issue, divide by zero, ignored starts and mid-operation reset.
module tb_md_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int errors = 0;
  int checks = 0;

  md_unit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .md_op    (md_op),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until busy falls (bounded); n counts edges, early counts done pulses seen while busy.
  task automatic wait_idle(output int n, output int early);
    n = 0;
    early = 0;
    while (busy && n < 100) begin
      tick();
      n++;
      if (busy && done) early++;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start = 1'b1;
    md_op = op;
    op_a  = a;
    op_b  = b;
  endtask

  int n, early, pulses;

  initial begin
    rst = 1'b1; start = 1'b0; md_op = 2'd0; op_a = '0; op_b = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz",   div_zero, 0);
    chk("rst_hi",   hi, 0);
    chk("rst_lo",   lo, 0);
    rst = 1'b0;

    // MULTU 7 x 9
    issue(2'd0, 32'd7, 32'd9);
    tick();
    start = 1'b0;
    chk("mul1_busy", busy, 1);
    chk("mul1_hold_lo", lo, 0);
    wait_idle(n, early);
    chk("mul1_cycles", n, 32);
    chk("mul1_early_done", early, 0);
    chk("mul1_done", done, 1);
    chk("mul1_hi", hi, 32'h0000_0000);
    chk("mul1_lo", lo, 32'h0000_003F);
    tick();
    chk("mul1_done_pulse", done, 0);

    // MULTU max x max, then DIVU 100/7 issued in the done cycle
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    start = 1'b0;
    wait_idle(n, early);
    chk("mul2_done", done, 1);
    chk("mul2_hi", hi, 32'hFFFF_FFFE);
    chk("mul2_lo", lo, 32'h0000_0001);
    issue(2'd1, 32'd100, 32'd7);
    tick();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    chk("div1_hold_hi", hi, 32'hFFFF_FFFE);
    wait_idle(n, early);
    chk("div1_cycles", n, 32);
    chk("div1_lo", lo, 32'd14);
    chk("div1_hi", hi, 32'd2);
    chk("div1_dz", div_zero, 0);

    // DIVU 5/0, then 9/3 clears the sticky flag
    issue(2'd1, 32'd5, 32'd0);
    tick();
    start = 1'b0;
    chk("dz_flag_early", div_zero, 1);
    wait_idle(n, early);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'h0000_0005);
    chk("dz_flag", div_zero, 1);
    tick();
    chk("dz_sticky", div_zero, 1);
    issue(2'd1, 32'd9, 32'd3);
    tick();
    start = 1'b0;
    chk("div2_dz_clr", div_zero, 0);
    wait_idle(n, early);
    chk("div2_lo", lo, 32'd3);
    chk("div2_hi", hi, 32'd0);

    // MTHI then MTLO on consecutive edges
    issue(2'd2, 32'hDEAD_BEEF, 32'd0);
    tick();
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_lo", lo, 32'd3);
    chk("mthi_busy", busy, 0);
    chk("mthi_done", done, 0);
    issue(2'd3, 32'h1234_5678, 32'd0);
    tick();
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h1234_5678);
    chk("mtlo_hi", hi, 32'hDEAD_BEEF);
    chk("mtlo_busy", busy, 0);
    chk("mtlo_done", done, 0);

    // MULTU 3x4 with a DIVU start presented while busy
    issue(2'd0, 32'd3, 32'd4);
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    issue(2'd1, 32'd100, 32'd7);
    tick();
    start = 1'b0;
    chk("ign_hold_hi", hi, 32'hDEAD_BEEF);
    chk("ign_hold_lo", lo, 32'h1234_5678);
    wait_idle(n, early);
    chk("ign_cycles", n + 5, 32);
    chk("ign_lo", lo, 32'd12);
    chk("ign_hi", hi, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    chk("ign_no_extra", pulses, 0);

    // DIVU 1000/10 aborted by reset
    issue(2'd1, 32'd1000, 32'd10);
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_done", done, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    issue(2'd0, 32'd2, 32'd3);
    tick();
    start = 1'b0;
    wait_idle(n, early);
    chk("post_lo", lo, 32'd6);
    chk("post_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Iterative HI/LO multiply/divide unit for the 5-stage MIPS pipeline, sitting in EX beside the ALU.
- Consumes the MDIV-class decode (MULTU, DIVU, MTHI, MTLO) and the forwarded rs/rt operands.
- Produces the HI/LO values read by MFHI/MFLO.
- Raises `busy` so the forwarding/hazard unit can stall dependent HI/LO instructions.
- Radix-2: one result bit per cycle, WIDTH cycles per multiply or divide.

Parameters:
- WIDTH, 32, operand width; also the iteration count per multiply/divide.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  EX-stage instruction is an MD op; sampled only when busy=0.
- md_op  input  2  operation: 0=MULTU, 1=DIVU, 2=MTHI, 3=MTLO.
- op_a  input  WIDTH  forwarded rs value (multiplicand / dividend / MT source).
- op_b  input  WIDTH  forwarded rt value (multiplier / divisor).
- busy  output  1  iterative operation in progress.
- done  output  1  one-cycle pulse when HI/LO receive a MULTU/DIVU result.
- div_zero  output  1  sticky flag: last DIVU had divisor 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
Reset:
- Synchronous, rst=1 at a rising edge: state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; internal counter/shift registers cleared.
- rst mid-operation aborts the operation with no HI/LO write.
- rst has priority over start.

States: IDLE, MUL, DIV.

IDLE:
- start=1 with md_op=MTHI at edge N: hi<=op_a at edge N; lo unchanged; busy stays 0; done stays 0.
- start=1 with md_op=MTLO: same, with lo<=op_a; hi unchanged.
- start=1 with MULTU: latch operands, clear 2*WIDTH accumulator, cnt<=0; go to MUL.
- start=1 with DIVU: latch operands, clear partial remainder, cnt<=0; go to DIV. div_zero<=(op_b==0) at edge N.

MUL:
- Each cycle: if multiplier LSB=1, add multiplicand into upper half of accumulator (WIDTH+1-bit sum, carry kept); shift accumulator right by 1; cnt++.

DIV:
- Restoring, unsigned.
- Each cycle: shift {rem, quotient} left by 1; trial = rem - divisor (WIDTH+1 bits).
- If no borrow: rem<=trial, quotient LSB=1; otherwise quotient LSB=0.
- cnt++.

Completion and timing:
- busy=1 in the cycles following edge N through edge N+WIDTH.
- At edge N+WIDTH: MUL writes hi<=product[2W-1:W], lo<=product[W-1:0]; DIV writes hi<=remainder, lo<=quotient.
- At that same edge: busy<=0, done<=1 for exactly one cycle; return to IDLE.
- Latency: WIDTH cycles from start edge to HI/LO valid.

Divide by zero:
- No special path; the restoring algorithm naturally yields lo=all ones, hi=op_a.
- div_zero=1 is held until the next DIVU start or rst.

Other rules:
- start while busy=1: ignored entirely; the upstream hazard unit guarantees a stall.
- hi/lo hold their previous values throughout busy; no partial results are visible.
- A new start is accepted in the cycle done=1 is high, i.e. back-to-back operations with no bubble.
- Unsigned only; no overflow exceptions.

Decomposition:
- Shared defines file (alongside ctrl_encode_def.v): MD_MULTU=2'd0, MD_DIVU=2'd1, MD_MTHI=2'd2, MD_MTLO=2'd3; state encodings MDS_IDLE/MDS_MUL/MDS_DIV.
- One sub-module, md_divstep: combinational single restoring-division step.
  - Inputs: rem, dividend MSB, divisor.
  - Outputs: next rem, quotient bit.
  - Instantiated once in DIV.
- Multiply step stays inline.

Test Plan:
- Reset, then MULTU op_a=7, op_b=9 -> busy high 32 cycles; done pulse; hi=0x00000000, lo=0x0000003F.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIVU 100/7 back-to-back on the done cycle -> lo=14, hi=2, div_zero=0.
- DIVU op_a=5, op_b=0 -> lo=0xFFFFFFFF, hi=0x00000005, div_zero=1; following DIVU 9/3 clears div_zero and gives lo=3, hi=0.
- MTHI 0xDEADBEEF then MTLO 0x12345678 on consecutive cycles -> hi/lo update on each edge; busy and done stay 0.
- Start MULTU 3x4, assert start with DIVU at cycle 5 -> second start ignored; lo=12 at cycle 32; no extra done.
- Start DIVU 1000/10, assert rst at cycle 10 -> next edge busy=0, hi=lo=0, done never pulses; a subsequent MULTU 2x3 gives lo=6.
